// File: rtl/gps_wb_master.sv
// Wishbone initiator that pulses the GPS genNext bit, polls codes_valid and
// reads the C/A, P and L code words into atomically-updated output registers.
module gps_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] POLL_MAX  = 16'd1000,
  parameter logic [7:0]  ACK_MAX   = 8'd255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   err_code,
  output logic [12:0]  ca_code,
  output logic [127:0] p_code,
  output logic [127:0] l_code,
  output logic [31:0]  wb_adr_o,
  output logic [31:0]  wb_dat_o,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  input  logic [31:0]  wb_dat_i,
  input  logic         wb_ack_i,
  input  logic         wb_err_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_GO, S_WR_CLR, S_POLL, S_RD, S_GAP, S_DONE, S_ABORT
  } state_e;

  state_e         state_q, ret_q;
  logic [3:0]     rd_idx_q;
  logic [15:0]    poll_cnt_q;
  logic [7:0]     ack_cnt_q;
  logic [12:0]    ca_stg_q;
  logic [127:0]   p_stg_q, l_stg_q;
  logic [1:0]     slot;
  logic           xfer;

  // regs 2..5 and 6..9 both map to slices 0..3 via the low index bits
  assign slot     = rd_idx_q[1:0] - 2'd2;
  assign xfer     = (state_q == S_WR_GO) || (state_q == S_WR_CLR) ||
                    (state_q == S_POLL)  || (state_q == S_RD);
  assign busy     = (state_q != S_IDLE);
  assign wb_sel_o = 4'hF;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      rd_idx_q   <= '0;
      poll_cnt_q <= '0;
      ack_cnt_q  <= '0;
      ca_stg_q   <= '0;
      p_stg_q    <= '0;
      l_stg_q    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
      ca_code    <= '0;
      p_code     <= '0;
      l_code     <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (xfer) begin
        if (wb_err_i) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          err_code <= 2'b01;
          error    <= 1'b1;
          state_q  <= S_ABORT;
        end else if (wb_ack_i) begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          ack_cnt_q <= '0;
          state_q   <= S_GAP;
          unique case (state_q)
            S_WR_GO:  ret_q <= S_WR_CLR;
            S_WR_CLR: ret_q <= S_POLL;
            S_POLL: begin
              if (wb_dat_i[0]) begin
                ret_q    <= S_RD;
                rd_idx_q <= 4'd1;
              end else if (poll_cnt_q + 16'd1 == POLL_MAX) begin
                err_code <= 2'b11;
                error    <= 1'b1;
                state_q  <= S_ABORT;
              end else begin
                poll_cnt_q <= poll_cnt_q + 16'd1;
                ret_q      <= S_POLL;
              end
            end
            default: begin
              if (rd_idx_q == 4'd1)      ca_stg_q <= wb_dat_i[12:0];
              else if (rd_idx_q <= 4'd5) p_stg_q[{slot, 5'd0} +: 32] <= wb_dat_i;
              else                       l_stg_q[{slot, 5'd0} +: 32] <= wb_dat_i;
              if (rd_idx_q == 4'd9) begin
                // last slice bypasses staging so outputs and done land together
                ca_code <= ca_stg_q;
                p_code  <= p_stg_q;
                l_code  <= {wb_dat_i, l_stg_q[95:0]};
                done    <= 1'b1;
                state_q <= S_DONE;
              end else begin
                rd_idx_q <= rd_idx_q + 4'd1;
                ret_q    <= S_RD;
              end
            end
          endcase
        end else if (ack_cnt_q == ACK_MAX - 8'd1) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          err_code <= 2'b10;
          error    <= 1'b1;
          state_q  <= S_ABORT;
        end else begin
          ack_cnt_q <= ack_cnt_q + 8'd1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: if (start) begin
            err_code   <= '0;
            poll_cnt_q <= '0;
            ack_cnt_q  <= '0;
            wb_adr_o   <= BASE_ADDR;
            wb_dat_o   <= 32'd1;
            wb_we_o    <= 1'b1;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            state_q    <= S_WR_GO;
          end
          S_GAP: begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_dat_o <= '0;
            wb_we_o  <= (ret_q == S_WR_CLR);
            wb_adr_o <= (ret_q == S_RD) ? BASE_ADDR + {26'd0, rd_idx_q, 2'b00}
                                        : BASE_ADDR;
            state_q  <= ret_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gps_wb_master.sv
// Randomized bench for gps_wb_master: behavioural Wishbone slave plus a
// round-level model of expected codes, latency and bus transfer sequence.
module tb_gps_wb_master;
  localparam logic [31:0] BASE = 32'h8000_0040;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, error;
  logic [1:0]   err_code;
  logic [12:0]  ca_code;
  logic [127:0] p_code, l_code;
  logic [31:0]  wb_adr_o, wb_dat_o;
  logic [3:0]   wb_sel_o;
  logic         wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0]  wb_dat_i = '0;
  logic         wb_ack_i = 1'b0;
  logic         wb_err_i = 1'b0;

  gps_wb_master #(.BASE_ADDR(BASE), .POLL_MAX(16'd5), .ACK_MAX(8'd255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .ca_code(ca_code), .p_code(p_code),
    .l_code(l_code), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // slave configuration and observation
  logic [31:0] regs [1:9];
  int  cfg_wait = 0, cfg_zeros = 0, cfg_err_reg = -1;
  bit  cfg_hold = 1'b0;
  int  poll_seen = 0, wcnt = 0, viol = 0, stb_cycles = 0;
  logic [64:0] blog[$];
  logic [31:0] p_adr = '0, p_dat = '0;
  logic        p_we = 1'b0, p_stb = 1'b0;

  // model of the last successfully delivered codes
  logic [12:0]  exp_ca = '0;
  logic [127:0] exp_p = '0, exp_l = '0;

  always @(negedge clk) begin : slave
    int idx;
    logic [31:0] r;
    if (wb_cyc_o !== wb_stb_o || wb_sel_o !== 4'hF) viol++;
    if (done && error) viol++;
    if (wb_stb_o && (wb_ack_i || wb_err_i)) viol++;
    if (wb_stb_o && p_stb && (wb_adr_o !== p_adr || wb_we_o !== p_we || wb_dat_o !== p_dat)) viol++;
    if (wb_stb_o && !wb_we_o && wb_dat_o !== 32'd0) viol++;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    if (wb_stb_o) begin
      stb_cycles++;
      if (!cfg_hold && wcnt >= cfg_wait) begin
        wcnt = 0;
        idx = int'((wb_adr_o - BASE) >> 2);
        if (!wb_we_o && idx == cfg_err_reg) begin
          wb_err_i = 1'b1;
          wb_ack_i = 1'($urandom_range(0, 1));
        end else begin
          wb_ack_i = 1'b1;
          if (!wb_we_o) begin
            if (idx == 0) begin
              r = $urandom;
              r[0] = (poll_seen >= cfg_zeros);
              poll_seen++;
              wb_dat_i = r;
            end else if (idx >= 1 && idx <= 9) wb_dat_i = regs[idx];
          end
          blog.push_back({wb_we_o, wb_adr_o, wb_dat_o});
        end
      end else wcnt++;
    end else wcnt = 0;
    p_stb = wb_stb_o; p_adr = wb_adr_o; p_we = wb_we_o; p_dat = wb_dat_o;
  end

  function automatic bit log_ok(input int polls);
    logic [64:0] e[$];
    e.push_back({1'b1, BASE, 32'd1});
    e.push_back({1'b1, BASE, 32'd0});
    for (int i = 0; i < polls; i++) e.push_back({1'b0, BASE, 32'd0});
    for (int n = 1; n <= 9; n++) e.push_back({1'b0, BASE + 32'(4 * n), 32'd0});
    if (e.size() != blog.size()) return 1'b0;
    foreach (e[i]) if (e[i] !== blog[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_regs_random();
    for (int n = 1; n <= 9; n++) regs[n] = $urandom;
  endtask

  task automatic prep(input int w, input int z);
    cfg_wait = w; cfg_zeros = z; cfg_err_reg = -1; cfg_hold = 1'b0;
    poll_seen = 0; stb_cycles = 0; viol = 0;
    blog.delete();
  endtask

  task automatic model_update();
    exp_ca = regs[1][12:0];
    exp_p  = {regs[5], regs[4], regs[3], regs[2]};
    exp_l  = {regs[9], regs[8], regs[7], regs[6]};
  endtask

  // cycle k = the cycle after the k-th edge following the start-sampling edge
  task automatic run_round(input int budget, output int dc, output int ec, output int bg);
    dc = -1; ec = -1; bg = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) bg++;
      if (done) dc = k;
      if (error) ec = k;
      if (done || error) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, err_code, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b done=%b err=%b code=%b cyc=%b stb=%b adr=%h want all 0",
        busy, done, error, err_code, wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    checks++;
    if ({ca_code, p_code, l_code} !== '0 || wb_sel_o !== 4'hF) begin
      errors++; $display("FAIL reset_codes: got ca=%h sel=%h want 0 / f", ca_code, wb_sel_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b stb=%b want 0 0", busy, wb_stb_o);
    end
  endtask

  task automatic test_basic();
    int dc, ec, bg;
    prep(0, 0);
    regs[1] = {$urandom_range(0, 32'h7FFFF), 13'h1ABC};
    for (int n = 2; n <= 9; n++) regs[n] = 32'(n - 1);
    run_round(200, dc, ec, bg);
    checks++;
    if (dc !== 24 || ec !== -1 || bg !== 0) begin
      errors++; $display("FAIL basic_latency: got done@%0d err@%0d busy_gaps=%0d want 24 -1 0", dc, ec, bg);
    end
    checks++;
    if (ca_code !== 13'h1ABC) begin
      errors++; $display("FAIL basic_ca: got %h want 1abc", ca_code);
    end
    checks++;
    if (p_code !== 128'h00000004_00000003_00000002_00000001 ||
        l_code !== 128'h00000008_00000007_00000006_00000005) begin
      errors++; $display("FAIL basic_pl: got p=%h l=%h", p_code, l_code);
    end
    checks++;
    if (!log_ok(1) || viol !== 0 || err_code !== 2'b00) begin
      errors++; $display("FAIL basic_bus: got log_ok=%0b viol=%0d code=%b want 1 0 00", log_ok(1), viol, err_code);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: got done=%b busy=%b after DONE want 0 0", done, busy);
    end
    model_update();
  endtask

  task automatic test_poll();
    int dc, ec, bg;
    prep(0, 3);
    set_regs_random();
    run_round(200, dc, ec, bg);
    model_update();
    checks++;
    if (dc !== 30 || poll_seen !== 4) begin
      errors++; $display("FAIL poll_latency: got done@%0d polls=%0d want 30 4", dc, poll_seen);
    end
    checks++;
    if (ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l || !log_ok(4)) begin
      errors++; $display("FAIL poll_codes: got ca=%h p=%h l=%h want ca=%h p=%h l=%h", ca_code, p_code, l_code, exp_ca, exp_p, exp_l);
    end
  endtask

  task automatic test_random();
    int dc, ec, bg, w, z;
    for (int r = 0; r < 6; r++) begin
      w = int'($urandom_range(0, 3));
      z = int'($urandom_range(0, 4));
      prep(w, z);
      set_regs_random();
      run_round(400, dc, ec, bg);
      model_update();
      checks++;
      if (dc !== (12 + z) * (2 + w) || ec !== -1 || bg !== 0) begin
        errors++; $display("FAIL rand_latency r%0d: got done@%0d err@%0d gaps=%0d want %0d", r, dc, ec, bg, (12 + z) * (2 + w));
      end
      checks++;
      if (ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l || !log_ok(z + 1) || viol !== 0) begin
        errors++; $display("FAIL rand_codes r%0d: got ca=%h p=%h l=%h viol=%0d want ca=%h p=%h l=%h", r, ca_code, p_code, l_code, viol, exp_ca, exp_p, exp_l);
      end
    end
  endtask

  task automatic test_poll_timeout();
    int dc, ec, bg;
    prep(0, 1000);
    set_regs_random();
    run_round(200, dc, ec, bg);
    checks++;
    if (ec !== 14 || dc !== -1 || err_code !== 2'b11 || poll_seen !== 5) begin
      errors++; $display("FAIL poll_timeout: got err@%0d done@%0d code=%b polls=%0d want 14 -1 11 5", ec, dc, err_code, poll_seen);
    end
    checks++;
    if (ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l) begin
      errors++; $display("FAIL poll_timeout_keep: got ca=%h p=%h want ca=%h p=%h", ca_code, p_code, exp_ca, exp_p);
    end
  endtask

  task automatic test_bus_error();
    int dc, ec, bg;
    prep(0, 0);
    cfg_err_reg = 5;
    set_regs_random();
    run_round(200, dc, ec, bg);
    checks++;
    if (ec !== 16 || dc !== -1 || err_code !== 2'b01 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL bus_err: got err@%0d done@%0d code=%b cyc=%b want 16 -1 01 0", ec, dc, err_code, wb_cyc_o);
    end
    checks++;
    if (ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l || viol !== 0) begin
      errors++; $display("FAIL bus_err_keep: got ca=%h viol=%0d want ca=%h 0", ca_code, viol, exp_ca);
    end
    prep(0, 0);
    set_regs_random();
    run_round(200, dc, ec, bg);
    model_update();
    checks++;
    if (dc !== 24 || err_code !== 2'b00 || ca_code !== exp_ca || l_code !== exp_l) begin
      errors++; $display("FAIL bus_err_recover: got done@%0d code=%b ca=%h want 24 00 %h", dc, err_code, ca_code, exp_ca);
    end
  endtask

  task automatic test_ack_timeout();
    int dc, ec, bg;
    prep(0, 0);
    cfg_hold = 1'b1;
    set_regs_random();
    run_round(400, dc, ec, bg);
    checks++;
    if (ec !== 256 || err_code !== 2'b10 || stb_cycles !== 255 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL ack_timeout: got err@%0d code=%b stb_cycles=%0d stb=%b want 256 10 255 0", ec, err_code, stb_cycles, wb_stb_o);
    end
    checks++;
    if (ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l) begin
      errors++; $display("FAIL ack_timeout_keep: got ca=%h want %h", ca_code, exp_ca);
    end
    cfg_hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dc = -1, dc2 = -1, low = 0;
    prep(0, 0);
    set_regs_random();
    model_update();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin dc = k; break; end
    end
    @(negedge clk);
    if (!busy) low++;
    @(negedge clk);
    if (!busy) low++;
    checks++;
    if (dc !== 24 || low !== 1 || wb_stb_o !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got done@%0d busy_low=%0d stb=%b want 24 1 1", dc, low, wb_stb_o);
    end
    start = 1'b0;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin dc2 = k; break; end
    end
    checks++;
    if (dc2 !== 24 || ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l) begin
      errors++; $display("FAIL b2b_second: got done@%0d ca=%h want 24 %h", dc2, ca_code, exp_ca);
    end
  endtask

  task automatic test_reset_mid();
    int dc, ec, bg;
    prep(0, 0);
    set_regs_random();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL rst_mid_bus: got cyc=%b stb=%b busy=%b done=%b err=%b want 0", wb_cyc_o, wb_stb_o, busy, done, error);
    end
    checks++;
    if ({ca_code, p_code, l_code, err_code} !== '0) begin
      errors++; $display("FAIL rst_mid_codes: got ca=%h p=%h code=%b want 0", ca_code, p_code, err_code);
    end
    rst = 1'b0;
    prep(0, 0);
    run_round(200, dc, ec, bg);
    model_update();
    checks++;
    if (dc !== 24 || ca_code !== exp_ca || p_code !== exp_p || l_code !== exp_l) begin
      errors++; $display("FAIL rst_mid_restart: got done@%0d ca=%h want 24 %h", dc, ca_code, exp_ca);
    end
  endtask

  initial begin
    for (int n = 1; n <= 9; n++) regs[n] = '0;
    test_reset();
    test_basic();
    test_poll();
    test_random();
    test_poll_timeout();
    test_bus_error();
    test_ack_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
